// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver. The bus inputs are synchronised and the clock is glitch-filtered.
// Bytes are delivered on a valid/ready port; parity, frame, timeout and overrun are one-cycle pulses.
//
// state  | meaning
// IDLE   | waiting for a start bit (dat=0 on a falling edge)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | waiting for the stop bit; frame outcome decided here
module ps2_frame_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       err_parity,
    output logic       err_frame,
    output logic       err_timeout,
    output logic       overrun
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic [FILTER_LEN-2:0]  hist_q, hist_d;
    logic [FILTER_LEN-1:0]  win;
    logic                   filt_q, filt_d;
    logic                   filt_dly_q, filt_dly_d;
    logic                   fe_q, fe_d;
    logic                   dat_s;

    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic [TW-1:0]          tmr_q, tmr_d;
    logic                   good;

    logic [7:0]             data_q, data_d;
    logic                   dv_q, dv_d;
    logic                   err_parity_q, err_parity_d;
    logic                   err_frame_q, err_frame_d;
    logic                   err_timeout_q, err_timeout_d;
    logic                   overrun_q, overrun_d;

    assign dat_s = dat_sync_q[SYNC_STAGES-1];

    // Filter window = current synced clk plus the previous FILTER_LEN-1 samples.
    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
        win        = {hist_q, clk_sync_q[SYNC_STAGES-1]};
        hist_d     = win[FILTER_LEN-2:0];
        filt_d     = filt_q;
        if (win == '0) begin
            filt_d = 1'b0;
        end else if (&win) begin
            filt_d = 1'b1;
        end
        filt_dly_d = filt_q;
        fe_d       = filt_dly_q & ~filt_q;
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        par_d         = par_q;
        tmr_d         = tmr_q;
        good          = 1'b0;
        err_parity_d  = 1'b0;
        err_frame_d   = 1'b0;
        err_timeout_d = 1'b0;
        if (fe_q) begin
            tmr_d = TMR_LOAD;
            unique case (state_q)
                S_IDLE: begin
                    if (!dat_s) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_d   = {dat_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_d   = dat_s;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (!dat_s) begin
                        err_frame_d = 1'b1;
                    end else if (!(^{shift_q, par_q})) begin
                        err_parity_d = 1'b1;
                    end else begin
                        good = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            // A falling edge in the expiry cycle takes the branch above, so it always wins.
            if (tmr_q == TW'(1)) begin
                state_d       = S_IDLE;
                err_timeout_d = 1'b1;
                tmr_d         = '0;
            end else if (tmr_q != '0) begin
                tmr_d = tmr_q - TW'(1);
            end
        end
    end

    always_comb begin
        data_d    = data_q;
        dv_d      = dv_q;
        overrun_d = 1'b0;
        if (good) begin
            if (!dv_q || data_ready) begin
                data_d = shift_q;
                dv_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (dv_q && data_ready) begin
            dv_d = 1'b0;
        end
    end

    // Conditioning flops reset to the bus idle level so release never looks like an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q    <= '1;
            dat_sync_q    <= '1;
            hist_q        <= '1;
            filt_q        <= 1'b1;
            filt_dly_q    <= 1'b1;
            fe_q          <= 1'b0;
            state_q       <= S_IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'h00;
            par_q         <= 1'b0;
            tmr_q         <= '0;
            data_q        <= 8'h00;
            dv_q          <= 1'b0;
            err_parity_q  <= 1'b0;
            err_frame_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            clk_sync_q    <= clk_sync_d;
            dat_sync_q    <= dat_sync_d;
            hist_q        <= hist_d;
            filt_q        <= filt_d;
            filt_dly_q    <= filt_dly_d;
            fe_q          <= fe_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            tmr_q         <= tmr_d;
            data_q        <= data_d;
            dv_q          <= dv_d;
            err_parity_q  <= err_parity_d;
            err_frame_q   <= err_frame_d;
            err_timeout_q <= err_timeout_d;
            overrun_q     <= overrun_d;
        end
    end

    assign data        = data_q;
    assign data_valid  = dv_q;
    assign err_parity  = err_parity_q;
    assign err_frame   = err_frame_q;
    assign err_timeout = err_timeout_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
`timescale 1ns/1ps
// Bench for ps2_frame_rx: drives PS/2 frames on the pins and scoreboards the bytes and pulses that come out.
module tb_ps2_frame_rx;
    localparam int SYNC_STAGES = 2;
    localparam int FILTER_LEN  = 4;
    localparam int TIMEOUT_CYC = 250;
    localparam int LAT         = SYNC_STAGES + FILTER_LEN + 2;
    localparam int P           = 80;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       ps2_clk    = 1'b1;
    logic       ps2_dat    = 1'b1;
    logic       data_ready = 1'b1;
    logic [7:0] data;
    logic       data_valid, err_parity, err_frame, err_timeout, overrun;

    int checks = 0;
    int errors = 0;
    int ncyc = 0;
    int fall_cyc = 0;
    int n_dv = 0, n_par = 0, n_frm = 0, n_tmo = 0, n_ovr = 0;
    int dv_rise_cyc = 0, par_cyc = 0, frm_cyc = 0, tmo_cyc = 0;
    logic dv_prev = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    ps2_frame_rx #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .err_parity (err_parity),
        .err_frame  (err_frame),
        .err_timeout(err_timeout),
        .overrun    (overrun)
    );

    always #500 clk = ~clk;
    always @(posedge clk) ncyc <= ncyc + 1;

    // Monitor: samples outputs mid-cycle, logs accepted bytes and pulse counts/times.
    always @(negedge clk) begin
        #1;
        if (!reset) begin
            if (data_valid) n_dv++;
            if (data_valid && !dv_prev) dv_rise_cyc = ncyc;
            if (err_parity) begin n_par++; par_cyc = ncyc; end
            if (err_frame) begin n_frm++; frm_cyc = ncyc; end
            if (err_timeout) begin n_tmo++; tmo_cyc = ncyc; end
            if (overrun) n_ovr++;
            if (data_valid && data_ready) obs_q.push_back(data);
        end
        dv_prev = data_valid;
    end

    initial begin
        #100_000_000;
        $display("FAIL watchdog: time limit reached, required completion before it");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_bit(input logic b, input int p);
        wait_cyc(p / 4);
        ps2_dat = b;
        wait_cyc(p / 2 - p / 4);
        ps2_clk  = 1'b0;
        fall_cyc = ncyc;
        wait_cyc(p / 2);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input int p);
        bus_bit(1'b0, p);
        for (int i = 0; i < 8; i++) bus_bit(b[i], p);
        bus_bit(par, p);
        bus_bit(stop, p);
        ps2_dat = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b, input int p);
        exp_q.push_back(b);
        send_frame(b, ~^b, 1'b1, p);
    endtask

    task automatic test_reset();
        wait_cyc(5);
        checks++;
        if ({data, data_valid, err_parity, err_frame, err_timeout, overrun} !== 13'h0)
            begin errors++; $display("FAIL reset_hold: outputs %h, required 0", {data, data_valid, err_parity, err_frame, err_timeout, overrun}); end
        reset = 1'b0;
        wait_cyc(20);
        checks++;
        if ({data, data_valid, err_parity, err_frame, err_timeout, overrun} !== 13'h0 || n_dv != 0)
            begin errors++; $display("FAIL reset_release: outputs %h dv_cycles %0d, required 0", {data, data_valid, err_parity, err_frame, err_timeout, overrun}, n_dv); end
    endtask

    task automatic test_basic();
        int dv0, e0;
        logic [7:0] got, exp;
        dv0 = n_dv; e0 = n_par + n_frm + n_tmo + n_ovr;
        send_good(8'hA5, P);
        wait_cyc(20);
        checks++;
        if (n_dv - dv0 != 1) begin errors++; $display("FAIL basic_valid_width: %0d cycles, required 1", n_dv - dv0); end
        checks++;
        if (dv_rise_cyc - fall_cyc != LAT) begin errors++; $display("FAIL basic_latency: %0d cycles, required %0d", dv_rise_cyc - fall_cyc, LAT); end
        checks++;
        if (n_par + n_frm + n_tmo + n_ovr != e0) begin errors++; $display("FAIL basic_errors: %0d pulses, required 0", n_par + n_frm + n_tmo + n_ovr - e0); end
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (got !== exp) begin errors++; $display("FAIL basic_byte: got %h, required %h", got, exp); end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL basic_missing: %0d bytes pending, required 0", exp_q.size()); end
    endtask

    task automatic test_parity();
        int dv0, p0;
        dv0 = n_dv; p0 = n_par;
        send_frame(8'h00, 1'b0, 1'b1, P);
        wait_cyc(20);
        checks++;
        if (n_par - p0 != 1) begin errors++; $display("FAIL parity_pulse: %0d cycles, required 1", n_par - p0); end
        checks++;
        if (par_cyc - fall_cyc != LAT) begin errors++; $display("FAIL parity_latency: %0d cycles, required %0d", par_cyc - fall_cyc, LAT); end
        checks++;
        if (n_dv != dv0 || obs_q.size() != 0) begin errors++; $display("FAIL parity_valid: %0d valid cycles, required 0", n_dv - dv0); end
    endtask

    task automatic test_frame();
        int dv0, f0, p0;
        logic [7:0] got, exp;
        dv0 = n_dv; f0 = n_frm; p0 = n_par;
        send_frame(8'h3C, ~^8'h3C, 1'b0, P);
        wait_cyc(20);
        checks++;
        if (n_frm - f0 != 1 || n_par != p0) begin errors++; $display("FAIL frame_pulse: frame %0d parity %0d, required 1 and 0", n_frm - f0, n_par - p0); end
        checks++;
        if (n_dv != dv0) begin errors++; $display("FAIL frame_valid: %0d valid cycles, required 0", n_dv - dv0); end
        send_good(8'h7E, P);
        wait_cyc(20);
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (got !== exp) begin errors++; $display("FAIL frame_next_byte: got %h, required %h", got, exp); end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL frame_missing: %0d bytes pending, required 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        int t0, dv0;
        logic [7:0] got, exp;
        t0 = n_tmo; dv0 = n_dv;
        bus_bit(1'b0, P);
        for (int i = 0; i < 5; i++) bus_bit(1'b1, P);
        ps2_dat = 1'b1;
        for (int i = 0; i < 600 && n_tmo == t0; i++) wait_cyc(1);
        wait_cyc(5);
        checks++;
        if (n_tmo - t0 != 1) begin errors++; $display("FAIL timeout_pulse: %0d cycles, required 1", n_tmo - t0); end
        checks++;
        if (tmo_cyc - fall_cyc != LAT + TIMEOUT_CYC) begin errors++; $display("FAIL timeout_latency: %0d cycles, required %0d", tmo_cyc - fall_cyc, LAT + TIMEOUT_CYC); end
        checks++;
        if (n_dv != dv0) begin errors++; $display("FAIL timeout_valid: %0d valid cycles, required 0", n_dv - dv0); end
        send_good(8'h12, P);
        wait_cyc(20);
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (got !== exp) begin errors++; $display("FAIL timeout_next_byte: got %h, required %h", got, exp); end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL timeout_missing: %0d bytes pending, required 0", exp_q.size()); end
    endtask

    task automatic test_overrun();
        int o0;
        logic [7:0] got, exp;
        o0 = n_ovr;
        data_ready = 1'b0;
        send_good(8'h11, P);
        wait_cyc(20);
        send_frame(8'h22, ~^8'h22, 1'b1, P);
        wait_cyc(20);
        checks++;
        if (n_ovr - o0 != 1) begin errors++; $display("FAIL overrun_pulse: %0d cycles, required 1", n_ovr - o0); end
        checks++;
        if (data !== 8'h11 || data_valid !== 1'b1) begin errors++; $display("FAIL overrun_hold: data %h valid %b, required 11 and 1", data, data_valid); end
        data_ready = 1'b1;
        wait_cyc(5);
        checks++;
        if (data_valid !== 1'b0 || data !== 8'h11) begin errors++; $display("FAIL overrun_drain: data %h valid %b, required 11 and 0", data, data_valid); end
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (got !== exp) begin errors++; $display("FAIL overrun_byte: got %h, required %h", got, exp); end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL overrun_missing: %0d bytes pending, required 0", exp_q.size()); end
    endtask

    task automatic test_glitch();
        int e0;
        logic [7:0] b, got, exp;
        b = 8'h5A;
        e0 = n_par + n_frm + n_tmo + n_ovr;
        exp_q.push_back(b);
        bus_bit(1'b0, P);
        for (int i = 0; i < 4; i++) bus_bit(b[i], P);
        wait_cyc(10);
        ps2_clk = 1'b0;
        wait_cyc(2);
        ps2_clk = 1'b1;
        for (int i = 4; i < 8; i++) bus_bit(b[i], P);
        bus_bit(~^b, P);
        bus_bit(1'b1, P);
        wait_cyc(20);
        checks++;
        if (n_par + n_frm + n_tmo + n_ovr != e0) begin errors++; $display("FAIL glitch_errors: %0d pulses, required 0", n_par + n_frm + n_tmo + n_ovr - e0); end
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (got !== exp) begin errors++; $display("FAIL glitch_byte: got %h, required %h", got, exp); end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL glitch_missing: %0d bytes pending, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int e0;
        logic [7:0] got, exp;
        data_ready = 1'b0;
        send_frame(8'h66, ~^8'h66, 1'b1, P);
        wait_cyc(20);
        checks++;
        if (data !== 8'h66 || data_valid !== 1'b1) begin errors++; $display("FAIL rmid_preload: data %h valid %b, required 66 and 1", data, data_valid); end
        bus_bit(1'b0, P);
        bus_bit(1'b1, P);
        bus_bit(1'b0, P);
        wait_cyc(5);
        reset = 1'b1;
        #1;
        checks++;
        if ({data, data_valid, err_parity, err_frame, err_timeout, overrun} !== 13'h0)
            begin errors++; $display("FAIL rmid_clear: outputs %h, required 0", {data, data_valid, err_parity, err_frame, err_timeout, overrun}); end
        ps2_dat = 1'b1;
        wait_cyc(5);
        reset = 1'b0;
        data_ready = 1'b1;
        e0 = n_par + n_frm + n_tmo + n_ovr;
        wait_cyc(10);
        send_good(8'hF0, P);
        wait_cyc(20);
        checks++;
        if (n_par + n_frm + n_tmo + n_ovr != e0) begin errors++; $display("FAIL rmid_errors: %0d pulses, required 0", n_par + n_frm + n_tmo + n_ovr - e0); end
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (got !== exp) begin errors++; $display("FAIL rmid_byte: got %h, required %h", got, exp); end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_missing: %0d bytes pending, required 0", exp_q.size()); end
    endtask

    task automatic test_random();
        int e0, nb;
        logic [7:0] got, exp;
        e0 = n_par + n_frm + n_tmo + n_ovr;
        nb = 0;
        for (int i = 0; i < 50; i++) begin
            wait_cyc($urandom_range(100, 0));
            send_good(8'($urandom), $urandom_range(100, 60));
        end
        wait_cyc(20);
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            nb++;
            checks++;
            if (got !== exp) begin errors++; $display("FAIL random_byte %0d: got %h, required %h", nb, got, exp); end
        end
        checks++;
        if (nb != 50 || exp_q.size() != 0) begin errors++; $display("FAIL random_count: %0d bytes received, required 50", nb); end
        checks++;
        if (n_par + n_frm + n_tmo + n_ovr != e0) begin errors++; $display("FAIL random_errors: %0d pulses, required 0", n_par + n_frm + n_tmo + n_ovr - e0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame();
        test_timeout();
        test_overrun();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
